// File: rtl/spi_bridge.sv
// -----------------------------------------------------------------------------
// spi_bridge
//   SPI slave front end (mode 0, MSB first) feeding the instruction decoder.
//   The SPI pins are synchronised into the clk domain and edge-detected.
//   MOSI is deserialised into bytes that appear on data_in with a one-cycle
//   byte_sync strobe. The decoder's data_out byte is shifted out on MISO
//   during the following byte slot.
//
// Ports
//   clk       : peripheral clock, all logic on its rising edge
//   rst       : asynchronous, active-high reset
//   sclk      : SPI clock (async, idle low)
//   cs_n      : SPI chip select (async, active low)
//   mosi      : SPI data in, sampled on sclk rising edges
//   miso      : SPI data out, 0 whenever miso_oe is low
//   miso_oe   : pad output enable, high while armed and selected
//   byte_sync : one-cycle pulse, data_in holds a newly completed byte
//   data_in   : last received byte
//   data_out  : byte to transmit in the next byte slot
//   frame_err : one-cycle pulse when cs_n rises mid-byte
// -----------------------------------------------------------------------------
module spi_bridge #(
  parameter int SYNC_STAGES = 2  // minimum 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       byte_sync,
  output logic [7:0] data_in,
  input  logic [7:0] data_out,
  output logic       frame_err
);

  // Synchronisers plus one edge-detect flop for sclk and cs_n. mosi is taken
  // from the last sync stage so it lines up with the synced sclk.
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  // Shifts in ones after reset. Once its top bit is set, the synced cs_n
  // reflects a real pin sample rather than the reset value.
  logic [SYNC_STAGES-1:0] fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // cs_n resets to "deselected" so reset release never creates a fake edge.
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      fill      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values and the chains shift one stage per clock.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic rise, fall, cs_fall, cs_rise, active;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise    =  sclk_s & ~sclk_d;
  assign fall    = ~sclk_s &  sclk_d;
  assign cs_fall = ~cs_s   &  cs_d;
  assign cs_rise =  cs_s   & ~cs_d;

  // Frame state
  logic       armed, armed_nx;
  logic       cs_ok, cs_ok_nx;       // cs_n has been seen high since reset
  logic [2:0] bit_cnt, bit_cnt_nx;
  // Only the low seven received bits are kept; the eighth goes straight into
  // data_in together with them.
  logic [6:0] rx_shift, rx_nx;
  logic [7:0] tx_shift, tx_nx;
  logic       load_pend, load_pend_nx;
  logic [7:0] data_in_nx;
  logic       byte_sync_nx, frame_err_nx;

  assign active  = armed & ~cs_s;
  assign miso_oe = active;
  assign miso    = active & tx_shift[7];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    armed_nx     = armed;
    cs_ok_nx     = cs_ok | (fill[SYNC_STAGES-1] & cs_s);
    bit_cnt_nx   = bit_cnt;
    rx_nx        = rx_shift;
    tx_nx        = tx_shift;
    data_in_nx   = data_in;
    byte_sync_nx = 1'b0;
    frame_err_nx = 1'b0;
    load_pend_nx = byte_sync;

    if (cs_rise) begin
      // Deselect wins over any sclk edge in the same cycle.
      armed_nx     = 1'b0;
      frame_err_nx = (bit_cnt != 3'd0);
      bit_cnt_nx   = 3'd0;
    end else if (cs_fall) begin
      // A cs_n already low at reset release must not arm the frame.
      if (cs_ok) begin
        armed_nx   = 1'b1;
        bit_cnt_nx = 3'd0;
        tx_nx      = data_out;
      end
    end else if (active) begin
      if (load_pend) begin
        tx_nx = data_out;
      end else if (fall && bit_cnt != 3'd0) begin
        // The fall right after the 8th rise (bit_cnt wrapped to 0) is skipped
        // so the freshly loaded MSB stays on MISO for the next byte.
        tx_nx = {tx_shift[6:0], 1'b0};
      end
      if (rise) begin
        rx_nx      = {rx_shift[5:0], mosi_s};
        bit_cnt_nx = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          data_in_nx   = {rx_shift, mosi_s};
          byte_sync_nx = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed     <= 1'b0;
      cs_ok     <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      load_pend <= 1'b0;
      data_in   <= '0;
      byte_sync <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      armed     <= armed_nx;
      cs_ok     <= cs_ok_nx;
      bit_cnt   <= bit_cnt_nx;
      rx_shift  <= rx_nx;
      tx_shift  <= tx_nx;
      load_pend <= load_pend_nx;
      data_in   <= data_in_nx;
      byte_sync <= byte_sync_nx;
      frame_err <= frame_err_nx;
    end
  end

endmodule

// File: tb/tb_spi_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_bridge
//   Bench for spi_bridge. A bit-level SPI master drives the pins. A frame-level
//   model records which bytes and frame errors must appear. One compare process
//   checks the DUT against that model on every clock. Hand-computed literals
//   check MISO bytes and final data_in values.
// -----------------------------------------------------------------------------
module tb_spi_bridge;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi;
  logic       miso, miso_oe, byte_sync, frame_err;
  logic [7:0] data_in, data_out;

  always #5 clk = ~clk;

  spi_bridge #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .byte_sync(byte_sync),
    .data_in(data_in), .data_out(data_out), .frame_err(frame_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // Written only by the stimulus process.
  logic [7:0] exp_q[$];               // bytes that must appear on data_in
  int         ferr_expected = 0;
  logic       exp_armed     = 1'b0;
  int         frame_bits    = 0;
  logic [7:0] sent_shift    = 8'h00;
  logic [7:0] resp_default  = 8'h00;
  // Written only by the compare process.
  int         exp_rd     = 0;
  int         ferr_seen  = 0;
  int         n_sync     = 0;
  int         cs_hi_cnt  = 0;
  int         cs_lo_cnt  = 0;
  logic [7:0] model_last = 8'h00;

  // Decoder stand-in: a read command 0x07 answers 0xA5, anything else answers
  // resp_default. The answer is valid from the cycle after byte_sync.
  always @(negedge clk) begin
    if (byte_sync) data_out = (data_in == 8'h07) ? 8'hA5 : resp_default;
    else if (cs_n) data_out = resp_default;
  end

  // Compare process
  always @(negedge clk) begin
    if (cs_n) begin cs_hi_cnt++; cs_lo_cnt = 0; end
    else      begin cs_lo_cnt++; cs_hi_cnt = 0; end
    if (rst) begin
      model_last = 8'h00;
      check("reset_outputs", 32'({byte_sync, frame_err, miso, miso_oe, data_in}), 32'd0);
    end else begin
      if (byte_sync) begin
        n_sync++;
        if (exp_rd < exp_q.size()) begin
          check("data_in", 32'(data_in), 32'(exp_q[exp_rd]));
          model_last = exp_q[exp_rd];
          exp_rd++;
        end else begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte_sync data_in=0x%0h at %0t", data_in, $time);
        end
      end else begin
        check("data_in_hold", 32'(data_in), 32'(model_last));
      end
      if (frame_err) begin
        ferr_seen++;
        check("frame_err_expected", 32'(ferr_seen <= ferr_expected), 32'd1);
      end
      check("miso_gated", 32'(miso & ~miso_oe), 32'd0);
      if (cs_hi_cnt >= SYNC_STAGES + 3 || (!cs_n && !exp_armed))
        check("idle_pins", 32'({miso_oe, miso}), 32'd0);
      if (!cs_n && exp_armed && cs_lo_cnt >= SYNC_STAGES + 3)
        check("miso_oe_armed", 32'(miso_oe), 32'd1);
    end
  end

  // ---------------- SPI master ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic cs_low();
    exp_armed  = 1'b1;
    frame_bits = 0;
    cs_n       = 1'b0;
    tick(SYNC_STAGES + 4);
  endtask

  task automatic cs_high(input int half);
    tick(half);
    cs_n = 1'b1;
    if (exp_armed && (frame_bits % 8) != 0) ferr_expected++;
    exp_armed = 1'b0;
    tick(SYNC_STAGES + 8);
    check("missing_byte_sync", 32'(exp_q.size() - exp_rd), 32'd0);
    check("missing_frame_err", 32'(ferr_expected - ferr_seen), 32'd0);
  endtask

  task automatic send_bit(input logic b, input int half, output logic mi);
    mosi = b;
    tick(half);
    mi   = miso;                       // master samples MISO at the rising edge
    sclk = 1'b1;
    if (!cs_n && exp_armed) begin
      sent_shift = {sent_shift[6:0], b};
      frame_bits++;
      if ((frame_bits % 8) == 0) exp_q.push_back(sent_shift);
    end
    tick(half);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int half,
                           output logic [7:0] mi);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], half, m);
      mi[i] = m;
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [7:0] mi0, mi1;
    logic       m;
    int         s0, f0;

    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(6);

    // Write frame at clk/16
    s0 = n_sync;
    resp_default = 8'h00;
    cs_low();
    send_byte(8'h85, 8, mi0);
    send_byte(8'h3C, 8, mi1);
    cs_high(8);
    check("write_sync_count", 32'(n_sync - s0), 32'd2);
    check("write_last_byte", 32'(data_in), 32'h3C);

    // Read frame: command 0x07, response 0xA5 during the second byte
    cs_low();
    send_byte(8'h07, 8, mi0);
    send_byte(8'h00, 8, mi1);
    cs_high(8);
    check("read_slot0_miso", 32'(mi0), 32'h00);
    check("read_resp_miso", 32'(mi1), 32'hA5);

    // Abort after 5 bits, then a clean frame
    f0 = ferr_seen;
    s0 = n_sync;
    cs_low();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 6, m);
    cs_high(6);
    check("abort_frame_err", 32'(ferr_seen - f0), 32'd1);
    check("abort_no_sync", 32'(n_sync - s0), 32'd0);
    check("abort_data_hold", 32'(data_in), 32'h00);
    cs_low();
    send_byte(8'h5A, 6, mi0);
    cs_high(6);
    check("after_abort_byte", 32'(data_in), 32'h5A);

    // Deselected noise
    s0 = n_sync;
    for (int i = 0; i < 20; i++) send_bit(i[0], 3, m);
    tick(6);
    check("noise_no_sync", 32'(n_sync - s0), 32'd0);
    check("noise_pins", 32'({miso_oe, miso}), 32'd0);

    // Reset mid-byte with cs_n held low
    cs_low();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 6, m);
    rst        = 1'b1;
    exp_armed  = 1'b0;
    frame_bits = 0;
    tick(3);
    rst = 1'b0;
    tick(6);
    s0 = n_sync;
    send_byte(8'hAA, 6, mi0);
    tick(6);
    check("post_reset_ignored", 32'(n_sync - s0), 32'd0);
    check("post_reset_data_in", 32'(data_in), 32'h00);
    cs_high(6);
    cs_low();
    send_byte(8'hFF, 6, mi0);
    cs_high(6);
    check("post_reset_byte", 32'(data_in), 32'hFF);

    // Minimum sclk half-period, back-to-back bytes
    s0 = n_sync;
    resp_default = 8'h81;
    tick(2);
    cs_low();
    send_byte(8'h00, SYNC_STAGES + 3, mi0);
    send_byte(8'hFF, SYNC_STAGES + 3, mi1);
    cs_high(SYNC_STAGES + 3);
    check("min_sync_count", 32'(n_sync - s0), 32'd2);
    check("min_last_byte", 32'(data_in), 32'hFF);
    check("min_slot0_miso", 32'(mi0), 32'h81);
    check("min_slot1_miso", 32'(mi1), 32'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
